lift_call_scheduler: RTL and testbench
======================================

Name: lift_call_scheduler

Overview:
- Upstream request stage for the 3-floor lift controller.
- Latches hall/car call buttons and selects the next target floor in SCAN order (keep direction while calls remain ahead).
- Presents the target as a one-hot floor code with valid; the lift controller drives `cur_floor` back as one-hot.
- Also times the door-open interval and flags a move timeout.

Parameters:
- DOOR_CYCLES, 8, cycles `door_open` stays high per stop (≥1).
- MOVE_TIMEOUT, 64, cycles allowed in MOVE before FAULT (≥2).
- CNT_W, 7, counter width; must hold max(DOOR_CYCLES, MOVE_TIMEOUT).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- call_btn  in  3  per-floor call request, bit0=floor1, bit2=floor3; sampled every edge, level or pulse
- cur_floor  in  3  one-hot current floor from lift controller (001/010/100)
- target_floor  out  3  one-hot selected destination
- target_valid  out  1  high while a move is commanded (MOVE state)
- dir_up  out  1  1 = travelling/last travelled up, 0 = down
- pending  out  3  latched outstanding calls (lamp drive)
- door_open  out  1  door-open command
- fault  out  1  sticky move-timeout flag

Behaviour:
- Reset values: state IDLE, pending 000, target_floor 001, target_valid 0, dir_up 1, door_open 0, fault 0, counters 0.
- States: IDLE, MOVE, DOOR, FAULT.
- pending update, each edge: pending <= (pending | call_btn) & ~clr.
  - clr = cur_floor on the edge entering DOOR.
  - clr = cur_floor every edge while in DOOR (a call at the open floor is absorbed).
  - Otherwise clr = 0. A set of any other floor always wins.
- cur_floor not one-hot: no arrival and no selection that cycle; state holds; timeout counter still runs in MOVE.
- Target selection (combinational, from registered pending and cur_floor):
  - ahead = pending floors strictly above (dir_up=1) or below (dir_up=0) cur_floor.
  - If ahead is non-empty: nearest ahead floor.
  - Else if pending floors exist behind: nearest behind floor, and dir flips.
  - Else none.
- IDLE:
  - pending & cur_floor ≠ 0 → DOOR.
  - Else if a selection exists → MOVE: latch target_floor and dir_up, zero the timeout counter.
  - Else stay.
- MOVE:
  - target_valid=1.
  - Every cycle, target_floor is re-evaluated in the current direction only. A new call between cur_floor and target_floor retargets to it; dir never flips in MOVE.
  - cur_floor == target_floor → DOOR; clear that pending bit on the same edge.
  - Timeout counter reaches MOVE_TIMEOUT-1 without arrival → FAULT. Arrival on that same edge wins.
- DOOR:
  - door_open=1, target_valid=0.
  - The counter runs 0..DOOR_CYCLES-1, then → IDLE.
  - call_btn for cur_floor during DOOR restarts the counter at 0.
- FAULT: fault=1, target_valid=0, door_open=0. pending keeps accumulating. Exit only via reset.
- Latency:
  - Call sampled at edge E is visible on `pending` after E.
  - From IDLE, target_valid rises after E+1.
  - door_open rises on the edge after arrival, stays high exactly DOOR_CYCLES cycles, and is low the next cycle.
- Reset asserted mid-MOVE or mid-DOOR: all outputs return to reset values at that edge; pending calls are discarded.
- Outputs are registered except `pending`, which is a register output directly.

Decomposition:
- lift_pkg:
  - FLOOR1=3'b001, FLOOR2=3'b010, FLOOR3=3'b100.
  - State encoding for IDLE/MOVE/DOOR/FAULT.
  - DIR_UP=1'b1 / DIR_DN=1'b0.
  - Shared with the lift controller.
- Sub-module lift_next_target:
  - Purely combinational.
  - Inputs: pending, cur_floor, dir_up, restrict_dir.
  - Outputs: sel_valid, sel_floor, sel_dir.
  - restrict_dir=1 in MOVE suppresses reversal.

Test Plan:
1. Reset low 2 cycles, release, call_btn=100 one cycle with cur_floor=001 → pending=100 next cycle; target_valid=1, target_floor=100, dir_up=1 one cycle later.
2. Continuing 1: drive cur_floor=010 then 100 → on the 100 edge pending[2] clears; door_open high exactly 8 cycles; then IDLE with target_valid=0.
3. Moving 001→100, call_btn=010 while cur_floor=001 → target_floor retargets to 010; stop at 2 with door_open; then resume to 100.
4. At floor 2, dir_up=1, pending=001 only → dir_up=0, target_floor=001 (reversal); with pending=101, go to 100 first.
5. In DOOR at floor 1, pulse call_btn=001 at door cycle 5 → counter restarts; door_open total 6+8=14 cycles; pending[0] stays 0.
6. MOVE with cur_floor held 001 for 64 cycles → fault=1, target_valid=0, state FAULT persists; reset=0 for 1 cycle → fault=0, pending=000.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared floor codes, direction and state encoding for the lift scheduler and controller.
// Also carries small one-hot helpers used by the target selector.
package lift_pkg;

  localparam logic [2:0] FLOOR1 = 3'b001;
  localparam logic [2:0] FLOOR2 = 3'b010;
  localparam logic [2:0] FLOOR3 = 3'b100;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DOOR  = 2'd2,
    FAULT = 2'd3
  } state_t;

  function automatic logic is_onehot(input logic [2:0] f);
    return (f == FLOOR1) || (f == FLOOR2) || (f == FLOOR3);
  endfunction

  function automatic logic [2:0] lowest_bit(input logic [2:0] x);
    return x & (~x + 3'd1);
  endfunction

  function automatic logic [2:0] highest_bit(input logic [2:0] x);
    logic [2:0] r;
    if (x[2])      r = FLOOR3;
    else if (x[1]) r = FLOOR2;
    else if (x[0]) r = FLOOR1;
    else           r = 3'b000;
    return r;
  endfunction

endpackage

// File: rtl/lift_next_target.sv
// SCAN-order next-floor selector; purely combinational.
// restrict_dir suppresses reversal so a moving car only retargets to closer calls ahead.
module lift_next_target
  import lift_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [2:0] cur_floor,
  input  logic       dir_up,
  input  logic       restrict_dir,
  output logic       sel_valid,
  output logic [2:0] sel_floor,
  output logic       sel_dir
);

  logic [2:0] above;
  logic [2:0] below;
  logic [2:0] ahead;
  logic [2:0] behind;

  // Strictly above / below the current floor; the current floor itself is never a target.
  assign above  = {cur_floor[1] | cur_floor[0], cur_floor[0], 1'b0};
  assign below  = {1'b0, cur_floor[2], cur_floor[2] | cur_floor[1]};
  assign ahead  = pending & (dir_up ? above : below);
  assign behind = pending & (dir_up ? below : above);

  always_comb begin
    sel_valid = 1'b0;
    sel_floor = cur_floor;
    sel_dir   = dir_up;
    if (is_onehot(cur_floor)) begin
      if (ahead != 3'b000) begin
        sel_valid = 1'b1;
        sel_floor = dir_up ? lowest_bit(ahead) : highest_bit(ahead);
      end else if (!restrict_dir && (behind != 3'b000)) begin
        sel_valid = 1'b1;
        sel_floor = dir_up ? highest_bit(behind) : lowest_bit(behind);
        sel_dir   = ~dir_up;
      end
    end
  end

endmodule

// File: rtl/lift_call_scheduler.sv
// Latches lift calls, commands the next SCAN-order target, times the door and flags move timeouts.
// Calls show on pending one edge after sampling; target_valid rises one edge after that from IDLE.
module lift_call_scheduler
  import lift_pkg::*;
#(
  parameter int DOOR_CYCLES  = 8,
  parameter int MOVE_TIMEOUT = 64,
  parameter int CNT_W        = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] call_btn,
  input  logic [2:0] cur_floor,
  output logic [2:0] target_floor,
  output logic       target_valid,
  output logic       dir_up,
  output logic [2:0] pending,
  output logic       door_open,
  output logic       fault
);

  state_t           state_q;
  logic [2:0]       pending_q, pending_d;
  logic [2:0]       target_q;
  logic             tvalid_q;
  logic             dir_q;
  logic             door_q;
  logic             fault_q;
  logic [CNT_W-1:0] cnt_q;

  logic             sel_valid;
  logic [2:0]       sel_floor;
  logic             sel_dir;
  logic             cur_ok;
  logic             enter_door;
  logic [2:0]       clr;

  lift_next_target u_sel (
    .pending      (pending_q),
    .cur_floor    (cur_floor),
    .dir_up       (dir_q),
    .restrict_dir (state_q == MOVE),
    .sel_valid    (sel_valid),
    .sel_floor    (sel_floor),
    .sel_dir      (sel_dir)
  );

  always_comb begin
    cur_ok     = is_onehot(cur_floor);
    enter_door = cur_ok &&
                 (((state_q == IDLE) && ((pending_q & cur_floor) != 3'b000)) ||
                  ((state_q == MOVE) && (cur_floor == target_q)));
    clr        = (enter_door || (state_q == DOOR)) ? cur_floor : 3'b000;
    pending_d  = (pending_q | call_btn) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 3'b000;
      target_q  <= FLOOR1;
      tvalid_q  <= 1'b0;
      dir_q     <= DIR_UP;
      door_q    <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (enter_door) begin
            state_q <= DOOR;
            door_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (sel_valid) begin
            state_q  <= MOVE;
            target_q <= sel_floor;
            dir_q    <= sel_dir;
            tvalid_q <= 1'b1;
            cnt_q    <= '0;
          end
        end
        MOVE: begin
          // Arrival takes priority over a timeout on the same edge.
          if (enter_door) begin
            state_q  <= DOOR;
            tvalid_q <= 1'b0;
            door_q   <= 1'b1;
            cnt_q    <= '0;
          end else if (cnt_q == CNT_W'(MOVE_TIMEOUT - 1)) begin
            state_q  <= FAULT;
            tvalid_q <= 1'b0;
            fault_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (sel_valid) target_q <= sel_floor;
          end
        end
        DOOR: begin
          if ((call_btn & cur_floor) != 3'b000) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(DOOR_CYCLES - 1)) begin
            state_q <= IDLE;
            door_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FAULT: begin
          fault_q  <= 1'b1;
          tvalid_q <= 1'b0;
          door_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign target_floor = target_q;
  assign target_valid = tvalid_q;
  assign dir_up       = dir_q;
  assign pending      = pending_q;
  assign door_open    = door_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Scoreboarded bench: a floor-number reference model predicts each cycle's outputs, a monitor compares.
// A simple plant model moves the car toward the commanded target to close the loop.
module tb_lift_call_scheduler;

  localparam int DC = 8;
  localparam int MT = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] call_btn = 3'b000;
  logic [2:0] cur_floor = 3'b001;
  logic [2:0] target_floor;
  logic       target_valid;
  logic       dir_up;
  logic [2:0] pending;
  logic       door_open;
  logic       fault;

  always #5 clk = ~clk;

  lift_call_scheduler #(.DOOR_CYCLES(DC), .MOVE_TIMEOUT(MT), .CNT_W(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .call_btn     (call_btn),
    .cur_floor    (cur_floor),
    .target_floor (target_floor),
    .target_valid (target_valid),
    .dir_up       (dir_up),
    .pending      (pending),
    .door_open    (door_open),
    .fault        (fault)
  );

  // Reference model: floors are numbers 1..3, state 0=idle 1=moving 2=door 3=fault.
  int       m_st = 0;
  bit [3:1] m_pend = '0;
  int       m_tgt = 1;
  bit       m_up = 1'b1;
  bit       m_tv = 1'b0;
  bit       m_door = 1'b0;
  bit       m_fault = 1'b0;
  int       m_cnt = 0;

  logic [9:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int pos = 1;
  bit auto_move = 1'b1;
  bit glitch_en = 1'b0;

  function automatic int floor_of(input logic [2:0] f);
    int r;
    r = 0;
    if (f == 3'b001) r = 1;
    else if (f == 3'b010) r = 2;
    else if (f == 3'b100) r = 3;
    return r;
  endfunction

  // Nearest pending floor in travel direction; optionally the nearest behind with a reversal.
  function automatic int pick(input int cur, input bit up, input bit allow_rev, output bit new_up);
    int f;
    new_up = up;
    for (int d = 1; d <= 2; d++) begin
      f = up ? cur + d : cur - d;
      if (f >= 1 && f <= 3 && m_pend[f]) return f;
    end
    if (allow_rev) begin
      for (int d = 1; d <= 2; d++) begin
        f = up ? cur - d : cur + d;
        if (f >= 1 && f <= 3 && m_pend[f]) begin
          new_up = ~up;
          return f;
        end
      end
    end
    return 0;
  endfunction

  function automatic logic [9:0] m_out();
    logic [2:0] t;
    logic [2:0] p;
    t = 3'b000;
    t[m_tgt-1] = 1'b1;
    p = {m_pend[3], m_pend[2], m_pend[1]};
    return {t, m_tv, m_up, p, m_door, m_fault};
  endfunction

  task automatic model_step(input logic rst, input logic [2:0] btn, input logic [2:0] cur);
    int c;
    int f;
    bit nu;
    bit [3:1] clr;
    if (!rst) begin
      m_st = 0; m_pend = '0; m_tgt = 1; m_up = 1'b1;
      m_tv = 1'b0; m_door = 1'b0; m_fault = 1'b0; m_cnt = 0;
      return;
    end
    c = floor_of(cur);
    clr = '0;
    case (m_st)
      0: begin
        if (c != 0 && m_pend[c]) begin
          m_st = 2; clr[c] = 1'b1; m_cnt = 0; m_door = 1'b1;
        end else if (c != 0) begin
          f = pick(c, m_up, 1'b1, nu);
          if (f != 0) begin
            m_st = 1; m_tgt = f; m_up = nu; m_tv = 1'b1; m_cnt = 0;
          end
        end
      end
      1: begin
        if (c != 0 && c == m_tgt) begin
          m_st = 2; clr[c] = 1'b1; m_tv = 1'b0; m_door = 1'b1; m_cnt = 0;
        end else if (m_cnt == MT - 1) begin
          m_st = 3; m_tv = 1'b0; m_fault = 1'b1;
        end else begin
          m_cnt++;
          if (c != 0) begin
            f = pick(c, m_up, 1'b0, nu);
            if (f != 0) m_tgt = f;
          end
        end
      end
      2: begin
        clr = {cur[2], cur[1], cur[0]};
        if ((btn & cur) != 3'b000) m_cnt = 0;
        else if (m_cnt == DC - 1) begin
          m_st = 0; m_door = 1'b0; m_cnt = 0;
        end else m_cnt++;
      end
      default: ;
    endcase
    m_pend = (m_pend | {btn[2], btn[1], btn[0]}) & ~clr;
  endtask

  // Monitor: one expectation per clock edge, compared half a cycle later.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [9:0] g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {target_floor, target_valid, dir_up, pending, door_open, fault};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got tgt=%b tv=%b up=%b pend=%b door=%b flt=%b want tgt=%b tv=%b up=%b pend=%b door=%b flt=%b",
                 $time, g[9:7], g[6], g[5], g[4:2], g[1], g[0],
                 e[9:7], e[6], e[5], e[4:2], e[1], e[0]);
      end
    end
  end

  task automatic step(input logic rst, input logic [2:0] btn);
    @(negedge clk);
    #1;
    if (auto_move && m_tv && (m_tgt != pos) && ($urandom_range(1, 0) == 1))
      pos = (m_tgt > pos) ? pos + 1 : pos - 1;
    reset    = rst;
    call_btn = btn;
    if (glitch_en && m_st == 1 && $urandom_range(19, 0) == 0) cur_floor = 3'b000;
    else cur_floor = 3'b001 << (pos - 1);
    @(posedge clk);
    model_step(reset, call_btn, cur_floor);
    exp_q.push_back(m_out());
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 3'b000);
  endtask

  task automatic wait_door_cnt(input int floor, input int c);
    int k;
    for (k = 0; k < 200; k++) begin
      if (m_st == 2 && m_cnt == c && pos == floor) break;
      step(1'b1, 3'b000);
    end
    n_tests++;
    if (k == 200) begin
      n_fail++;
      $display("FAIL door_wait got cycles=%0d want door cycle %0d at floor %0d", k, c, floor);
    end
  endtask

  initial begin
    logic [2:0] b;
    // Reset, then a single call to floor 3 from floor 1; the plant carries the car up.
    step(1'b0, 3'b000);
    step(1'b0, 3'b000);
    step(1'b1, 3'b100);
    idle_steps(30);

    // Back to floor 1, then up-trip to floor 3 retargeted by a floor-2 call.
    step(1'b1, 3'b001);
    idle_steps(30);
    auto_move = 1'b0;
    step(1'b1, 3'b100);
    step(1'b1, 3'b000);
    step(1'b1, 3'b010);
    step(1'b1, 3'b000);
    auto_move = 1'b1;
    idle_steps(40);

    // Reversal at floor 2 with only floor 1 pending, then 101 pending from floor 2 going up.
    step(1'b1, 3'b001);
    idle_steps(30);
    step(1'b1, 3'b010);
    idle_steps(25);
    step(1'b1, 3'b001);
    idle_steps(25);
    step(1'b1, 3'b010);
    idle_steps(25);
    auto_move = 1'b0;
    step(1'b1, 3'b101);
    step(1'b1, 3'b000);
    step(1'b1, 3'b000);
    auto_move = 1'b1;
    idle_steps(50);

    // Door restart: press the open floor's button at door cycle 5.
    step(1'b1, 3'b010);
    idle_steps(25);
    step(1'b1, 3'b001);
    wait_door_cnt(1, 5);
    step(1'b1, 3'b001);
    idle_steps(20);

    // Stuck car: move timeout to FAULT, calls still latch, then a one-cycle reset clears it.
    auto_move = 1'b0;
    step(1'b1, 3'b100);
    idle_steps(68);
    step(1'b1, 3'b010);
    step(1'b1, 3'b000);
    step(1'b0, 3'b000);
    idle_steps(3);

    // Randomised traffic with occasional cur_floor glitches and stalls.
    auto_move = 1'b1;
    glitch_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      b = 3'b000;
      for (int j = 0; j < 3; j++) if ($urandom_range(7, 0) == 0) b[j] = 1'b1;
      if (i % 500 == 400) begin
        auto_move = 1'b0;
        for (int k = 0; k < 70; k++) step(1'b1, ($urandom_range(9, 0) == 0) ? 3'b010 : 3'b000);
        step(1'b0, 3'b000);
        auto_move = 1'b1;
      end
      step(1'b1, b);
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d queued want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
